// File: rtl/trim_pkg.sv
// Shared types and sizing helpers for the serial trim-code generator.
package trim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_SETTLE
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Half-bit-period prescaler: one-cycle tick every HALF_DIV cycles, held at zero by clr.
module tick_div
    import trim_pkg::*;
#(
    parameter int HALF_DIV = 25000000
) (
    input  logic CLK50,
    input  logic RST_N,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = cnt_w(HALF_DIV);
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST) && !clr;

endmodule

// File: rtl/trim_sweep_gen.sv
// Serial trim-code generator: shifts a code out over a gated SCLK, strobes LATCH,
// settles, and optionally sweeps CODE_MIN..CODE_MAX in STEP increments.
module trim_sweep_gen
    import trim_pkg::*;
#(
    parameter int CODE_W      = 12,
    parameter int HALF_DIV    = 25000000,
    parameter int SETTLE_BITS = 3,
    parameter int CODE_MIN    = 0,
    parameter int CODE_MAX    = 2**CODE_W - 1,
    parameter int STEP        = 1,
    parameter int MSB_FIRST   = 0
) (
    input  logic              CLK50,
    input  logic              RST_N,
    input  logic              START,
    input  logic              MODE,
    input  logic [CODE_W-1:0] CODE_IN,
    input  logic              ABORT,
    output logic              DOUT,
    output logic              SCLK,
    output logic              LATCH,
    output logic              BUSY,
    output logic              DONE,
    output logic [CODE_W-1:0] CUR_CODE
);

    localparam int                BW       = cnt_w(2 * CODE_W);
    localparam int                SW       = cnt_w(2 * SETTLE_BITS);
    localparam int                XW       = CODE_W + 1;
    localparam logic [BW-1:0]     BIT_LAST = BW'(2 * CODE_W - 1);
    localparam logic [BW-1:0]     BIT_ONE  = BW'(1);
    localparam logic [SW-1:0]     SET_LAST = SW'(2 * SETTLE_BITS - 1);
    localparam logic [XW-1:0]     MAX_X    = XW'(CODE_MAX);
    localparam logic [XW-1:0]     STEP_X   = XW'(STEP);
    localparam logic [CODE_W-1:0] MIN_C    = CODE_W'(CODE_MIN);

    function automatic logic lead_bit(input logic [CODE_W-1:0] v);
        return (MSB_FIRST != 0) ? v[CODE_W-1] : v[0];
    endfunction

    function automatic logic [CODE_W-1:0] shift_out(input logic [CODE_W-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    state_t            r_state, w_nxt_state;
    logic              r_sclk, w_nxt_sclk;
    logic              r_dout, w_nxt_dout;
    logic              r_latch, w_nxt_latch;
    logic              r_done, w_nxt_done;
    logic              r_mode, w_nxt_mode;
    logic [CODE_W-1:0] r_cur_code, w_nxt_cur_code;
    logic [CODE_W-1:0] r_shreg, w_nxt_shreg;
    logic [BW-1:0]     r_bit, w_nxt_bit;
    logic [SW-1:0]     r_settle, w_nxt_settle;
    logic              r_start_q;

    logic              w_tick;
    logic              w_clr;
    logic              w_start_rise;
    logic [XW-1:0]     w_sum;
    logic [CODE_W-1:0] w_load_code;
    logic [CODE_W-1:0] w_shifted;

    // Prescaler only runs once the frame is under way; LOAD is an extra cycle.
    assign w_clr        = ABORT || (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign w_start_rise = START && !r_start_q;
    assign w_sum        = {1'b0, r_cur_code} + STEP_X;
    assign w_load_code  = MODE ? CODE_IN : MIN_C;
    assign w_shifted    = shift_out(r_shreg);

    tick_div #(
        .HALF_DIV(HALF_DIV)
    ) u_tick_div (
        .CLK50(CLK50),
        .RST_N(RST_N),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_sclk     <= 1'b0;
            r_dout     <= 1'b0;
            r_latch    <= 1'b0;
            r_done     <= 1'b0;
            r_mode     <= 1'b0;
            r_cur_code <= '0;
            r_shreg    <= '0;
            r_bit      <= '0;
            r_settle   <= '0;
            r_start_q  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_sclk     <= w_nxt_sclk;
            r_dout     <= w_nxt_dout;
            r_latch    <= w_nxt_latch;
            r_done     <= w_nxt_done;
            r_mode     <= w_nxt_mode;
            r_cur_code <= w_nxt_cur_code;
            r_shreg    <= w_nxt_shreg;
            r_bit      <= w_nxt_bit;
            r_settle   <= w_nxt_settle;
            r_start_q  <= START;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_sclk     = r_sclk;
        w_nxt_dout     = r_dout;
        w_nxt_latch    = r_latch;
        w_nxt_done     = 1'b0;
        w_nxt_mode     = r_mode;
        w_nxt_cur_code = r_cur_code;
        w_nxt_shreg    = r_shreg;
        w_nxt_bit      = r_bit;
        w_nxt_settle   = r_settle;

        if (ABORT) begin
            w_nxt_state = ST_IDLE;
            w_nxt_sclk  = 1'b0;
            w_nxt_dout  = 1'b0;
            w_nxt_latch = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_rise) w_nxt_state = ST_LOAD;
                end
                ST_LOAD: begin
                    w_nxt_mode     = MODE;
                    w_nxt_cur_code = w_load_code;
                    w_nxt_shreg    = w_load_code;
                    w_nxt_dout     = lead_bit(w_load_code);
                    w_nxt_sclk     = 1'b0;
                    w_nxt_latch    = 1'b0;
                    w_nxt_bit      = '0;
                    w_nxt_settle   = '0;
                    w_nxt_state    = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (r_bit == BIT_LAST) begin
                            w_nxt_sclk  = 1'b0;
                            w_nxt_dout  = 1'b0;
                            w_nxt_latch = 1'b1;
                            w_nxt_bit   = '0;
                            w_nxt_state = ST_LATCH;
                        end else begin
                            w_nxt_bit  = r_bit + BIT_ONE;
                            w_nxt_sclk = !r_sclk;
                            // New data only on the falling toggle keeps DOUT stable while SCLK is high.
                            if (r_sclk) begin
                                w_nxt_shreg = w_shifted;
                                w_nxt_dout  = lead_bit(w_shifted);
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (w_tick) begin
                        if (r_bit == BIT_ONE) begin
                            w_nxt_latch = 1'b0;
                            w_nxt_bit   = '0;
                            w_nxt_state = ST_SETTLE;
                        end else begin
                            w_nxt_bit = r_bit + BIT_ONE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (w_tick) begin
                        if (r_settle == SET_LAST) begin
                            w_nxt_settle = '0;
                            // The extra sum bit catches overflow past an all-ones CODE_MAX.
                            if (r_mode || (w_sum > MAX_X)) begin
                                w_nxt_done  = 1'b1;
                                w_nxt_state = ST_IDLE;
                            end else begin
                                w_nxt_cur_code = w_sum[CODE_W-1:0];
                                w_nxt_shreg    = w_sum[CODE_W-1:0];
                                w_nxt_dout     = lead_bit(w_sum[CODE_W-1:0]);
                                w_nxt_state    = ST_SHIFT;
                            end
                        end else begin
                            w_nxt_settle = r_settle + SW'(1);
                        end
                    end
                end
                default: w_nxt_state = ST_IDLE;
            endcase
        end
    end

    assign DOUT     = r_dout;
    assign SCLK     = r_sclk;
    assign LATCH    = r_latch;
    assign BUSY     = (r_state != ST_IDLE);
    assign DONE     = r_done;
    assign CUR_CODE = r_cur_code;

endmodule

// File: tb/tb_trim_sweep_gen.sv
// Self-checking bench for trim_sweep_gen: three configurations checked against a frame-level model.
module tb_trim_sweep_gen;

    localparam int CW    = 4;
    localparam int HD    = 2;
    localparam int SB    = 1;
    localparam int FRAME = (2 * CW + 2 + 2 * SB) * HD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] code_in = '0;
    logic          start [3];
    logic          dout  [3];
    logic          sclk  [3];
    logic          latch [3];
    logic          busy  [3];
    logic          done  [3];
    logic [CW-1:0] cur   [3];

    int checks = 0;
    int errors = 0;

    // Sweep configuration of each instance, mirrored for the model.
    int cmin_a [3] = '{2, 13, 12};
    int cmax_a [3] = '{9, 15, 5};
    int step_a [3] = '{3, 2, 1};
    int msb_a  [3] = '{0, 1, 0};

    logic [63:0] exp_bv, got_bv, exp_cv, got_cv;
    int exp_n, got_n, exp_frames, got_frames, exp_last;
    int busy_cyc, busy_first, latch_cyc, done_cnt, done_cyc, first_rise, viol, restarts;
    bit timeout;

    always #10 clk = ~clk;

    trim_sweep_gen #(.CODE_W(CW), .HALF_DIV(HD), .SETTLE_BITS(SB), .CODE_MIN(2), .CODE_MAX(9),
                     .STEP(3), .MSB_FIRST(0)) u_dut0 (
        .CLK50(clk), .RST_N(rst_n), .START(start[0]), .MODE(mode), .CODE_IN(code_in), .ABORT(abort),
        .DOUT(dout[0]), .SCLK(sclk[0]), .LATCH(latch[0]), .BUSY(busy[0]), .DONE(done[0]), .CUR_CODE(cur[0]));

    trim_sweep_gen #(.CODE_W(CW), .HALF_DIV(HD), .SETTLE_BITS(SB), .CODE_MIN(13),
                     .STEP(2), .MSB_FIRST(1)) u_dut1 (
        .CLK50(clk), .RST_N(rst_n), .START(start[1]), .MODE(mode), .CODE_IN(code_in), .ABORT(abort),
        .DOUT(dout[1]), .SCLK(sclk[1]), .LATCH(latch[1]), .BUSY(busy[1]), .DONE(done[1]), .CUR_CODE(cur[1]));

    trim_sweep_gen #(.CODE_W(CW), .HALF_DIV(HD), .SETTLE_BITS(SB), .CODE_MIN(12), .CODE_MAX(5),
                     .STEP(1), .MSB_FIRST(0)) u_dut2 (
        .CLK50(clk), .RST_N(rst_n), .START(start[2]), .MODE(mode), .CODE_IN(code_in), .ABORT(abort),
        .DOUT(dout[2]), .SCLK(sclk[2]), .LATCH(latch[2]), .BUSY(busy[2]), .DONE(done[2]), .CUR_CODE(cur[2]));

    // Frame-level model: list of codes the run must send, and the serial bit stream they produce.
    task automatic build_model(input int idx, input bit single, input int code);
        int c;
        int v;
        exp_bv = '0; exp_cv = '0; exp_n = 0; exp_frames = 0;
        c = single ? code : cmin_a[idx];
        forever begin
            exp_cv = {exp_cv[59:0], 4'(c)};
            exp_frames++;
            exp_last = c;
            v = c;
            for (int i = 0; i < CW; i++) begin
                exp_bv = {exp_bv[62:0], (msb_a[idx] != 0) ? v[CW-1-i] : v[i]};
                exp_n++;
            end
            c = c + step_a[idx];
            if (single || c > cmax_a[idx]) break;
        end
    endtask

    // Raise START on instance idx and record everything it does until it has been idle for a while.
    task automatic capture(input int idx, input bit hold, input int max_cyc);
        logic pb, ps, pl, pd;
        bit   fell;
        int   tail;
        pb = 0; ps = 0; pl = 0; pd = 0; fell = 0; tail = 0;
        got_bv = '0; got_cv = '0; got_n = 0; got_frames = 0;
        busy_cyc = 0; busy_first = -1; latch_cyc = 0; done_cnt = 0; done_cyc = -1;
        first_rise = -1; viol = 0; restarts = 0; timeout = 1;
        @(negedge clk);
        start[idx] = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (c == 2) begin
                mode    = ~mode;
                code_in = CW'($urandom);
                if (!hold) start[idx] = 1'b0;
            end
            if (busy[idx]) begin
                busy_cyc++;
                if (busy_first < 0) busy_first = c;
                if (!pb && fell) restarts++;
            end
            if (sclk[idx] && !ps) begin
                got_bv = {got_bv[62:0], dout[idx]};
                got_n++;
                if (first_rise < 0) first_rise = c;
            end
            if (sclk[idx] && ps && (dout[idx] !== pd)) viol++;
            if (latch[idx] && !pl) begin
                got_cv = {got_cv[59:0], cur[idx]};
                got_frames++;
            end
            if (latch[idx]) latch_cyc++;
            if (done[idx]) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                if (busy[idx]) viol++;
            end
            if (pb && !busy[idx]) fell = 1;
            pb = busy[idx]; ps = sclk[idx]; pl = latch[idx]; pd = dout[idx];
            if (fell) begin
                tail++;
                if (tail > 12) begin
                    timeout = 0;
                    break;
                end
            end
        end
        start[idx] = 1'b0;
    endtask

    task automatic test_reset();
        start[0] = 0; start[1] = 0; start[2] = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({dout[i], sclk[i], latch[i], busy[i], done[i], cur[i]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got %b exp 0", i,
                         {dout[i], sclk[i], latch[i], busy[i], done[i], cur[i]});
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single(input int idx);
        logic [CW-1:0] code;
        for (int r = 0; r < 4; r++) begin
            code    = (r == 0) ? 4'b1011 : CW'($urandom_range(0, 15));
            mode    = 1'b1;
            code_in = code;
            build_model(idx, 1, int'(code));
            capture(idx, 0, 200);
            checks++;
            if (timeout) begin errors++; $display("FAIL single_timeout dut%0d got busy %0d", idx, busy_cyc); end
            checks++;
            if (got_bv !== exp_bv || got_n !== exp_n)
                begin errors++; $display("FAIL single_bits dut%0d got %h/%0d exp %h/%0d", idx, got_bv, got_n, exp_bv, exp_n); end
            checks++;
            if (got_cv !== exp_cv || got_frames !== exp_frames)
                begin errors++; $display("FAIL single_code dut%0d got %h exp %h", idx, got_cv, exp_cv); end
            checks++;
            if (busy_first !== 1) begin errors++; $display("FAIL single_latency dut%0d got %0d exp 1", idx, busy_first); end
            checks++;
            if (first_rise !== 2 + HD) begin errors++; $display("FAIL single_first_rise dut%0d got %0d exp %0d", idx, first_rise, 2 + HD); end
            checks++;
            if (busy_cyc !== 1 + FRAME) begin errors++; $display("FAIL single_busy_len dut%0d got %0d exp %0d", idx, busy_cyc, 1 + FRAME); end
            checks++;
            if (latch_cyc !== 2 * HD) begin errors++; $display("FAIL single_latch_len dut%0d got %0d exp %0d", idx, latch_cyc, 2 * HD); end
            checks++;
            if (done_cnt !== 1 || done_cyc !== 2 + FRAME)
                begin errors++; $display("FAIL single_done dut%0d got %0d@%0d exp 1@%0d", idx, done_cnt, done_cyc, 2 + FRAME); end
            checks++;
            if (viol !== 0) begin errors++; $display("FAIL single_dout_stable dut%0d got %0d exp 0", idx, viol); end
        end
    endtask

    task automatic test_sweep(input int idx);
        mode = 1'b0;
        build_model(idx, 0, 0);
        capture(idx, 0, 600);
        checks++;
        if (timeout) begin errors++; $display("FAIL sweep_timeout dut%0d got busy %0d", idx, busy_cyc); end
        checks++;
        if (got_cv !== exp_cv || got_frames !== exp_frames)
            begin errors++; $display("FAIL sweep_codes dut%0d got %h/%0d exp %h/%0d", idx, got_cv, got_frames, exp_cv, exp_frames); end
        checks++;
        if (got_bv !== exp_bv || got_n !== exp_n)
            begin errors++; $display("FAIL sweep_bits dut%0d got %h exp %h", idx, got_bv, exp_bv); end
        checks++;
        if (busy_cyc !== 1 + FRAME * exp_frames)
            begin errors++; $display("FAIL sweep_busy_len dut%0d got %0d exp %0d", idx, busy_cyc, 1 + FRAME * exp_frames); end
        checks++;
        if (latch_cyc !== 2 * HD * exp_frames)
            begin errors++; $display("FAIL sweep_latch_len dut%0d got %0d exp %0d", idx, latch_cyc, 2 * HD * exp_frames); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL sweep_done dut%0d got %0d exp 1", idx, done_cnt); end
        checks++;
        if (int'(cur[idx]) !== exp_last) begin errors++; $display("FAIL sweep_last_code dut%0d got %0d exp %0d", idx, cur[idx], exp_last); end
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL sweep_dout_stable dut%0d got %0d exp 0", idx, viol); end
    endtask

    task automatic test_abort();
        int  rises;
        bit  hit;
        logic ps;
        int  stray;
        rises = 0; hit = 0; ps = 0; stray = 0;
        mode = 1'b1; code_in = 4'b0110;
        @(negedge clk);
        start[0] = 1'b1;
        for (int c = 1; c < 60; c++) begin
            @(negedge clk);
            if (c == 2) start[0] = 1'b0;
            if (sclk[0] && !ps) rises++;
            ps = sclk[0];
            if (rises == 2) begin hit = 1; break; end
        end
        start[0] = 1'b0;
        checks++;
        if (!hit) begin errors++; $display("FAIL abort_reach_bit2 got %0d rises exp 2", rises); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({sclk[0], dout[0], busy[0], latch[0]} !== 4'b0000)
            begin errors++; $display("FAIL abort_outputs got %b exp 0000", {sclk[0], dout[0], busy[0], latch[0]}); end
        checks++;
        if (cur[0] !== 4'b0110) begin errors++; $display("FAIL abort_cur_hold got %0d exp 6", cur[0]); end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done[0] || busy[0]) stray++;
        end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", stray); end
        mode = 1'b1; code_in = 4'b1001;
        build_model(0, 1, 9);
        capture(0, 0, 200);
        checks++;
        if (timeout || got_bv !== exp_bv || done_cnt !== 1 || busy_cyc !== 1 + FRAME)
            begin errors++; $display("FAIL abort_restart got bits %h done %0d busy %0d exp bits %h done 1 busy %0d",
                                     got_bv, done_cnt, busy_cyc, exp_bv, 1 + FRAME); end
    endtask

    task automatic test_hold_start();
        mode = 1'b1; code_in = CW'($urandom_range(0, 15));
        build_model(1, 1, int'(code_in));
        capture(1, 1, 200);
        checks++;
        if (timeout) begin errors++; $display("FAIL hold_timeout got busy %0d", busy_cyc); end
        checks++;
        if (restarts !== 0 || done_cnt !== 1)
            begin errors++; $display("FAIL hold_no_restart got restarts %0d done %0d exp 0 and 1", restarts, done_cnt); end
        checks++;
        if (got_bv !== exp_bv) begin errors++; $display("FAIL hold_bits got %h exp %h", got_bv, exp_bv); end
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 0;
        mode = 1'b1; code_in = 4'b1101;
        @(negedge clk);
        start[0] = 1'b1;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            if (c == 2) start[0] = 1'b0;
            if (sclk[0]) begin hit = 1; break; end
        end
        start[0] = 1'b0;
        checks++;
        if (!hit || !busy[0]) begin errors++; $display("FAIL rstmid_reach_shift got sclk %0b busy %0b exp 1 1", sclk[0], busy[0]); end
        #3 rst_n = 1'b0;
        #2;
        checks++;
        if ({dout[0], sclk[0], latch[0], busy[0], done[0], cur[0]} !== '0)
            begin errors++; $display("FAIL rstmid_async got %b exp 0", {dout[0], sclk[0], latch[0], busy[0], done[0], cur[0]}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single(0);
        test_single(1);
        test_sweep(0);
        test_sweep(1);
        test_sweep(2);
        test_abort();
        test_hold_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish exp finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
